// File: rtl/validacion_pkg.sv
// Shared encodings and defaults for the entry-validation controller.
package validacion_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ETAPA_T = 3'd1;
    localparam logic [2:0] ST_ETAPA_P = 3'd2;
    localparam logic [2:0] ST_ETAPA_B = 3'd3;
    localparam logic [2:0] ST_BLOQUEO = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        ETAPA_T = ST_ETAPA_T,
        ETAPA_P = ST_ETAPA_P,
        ETAPA_B = ST_ETAPA_B,
        BLOQUEO = ST_BLOQUEO
    } estado_t;

    localparam logic [1:0] ETAPA_NINGUNA = 2'd0;
    localparam logic [1:0] ETAPA_COD_T   = 2'd1;
    localparam logic [1:0] ETAPA_COD_P   = 2'd2;
    localparam logic [1:0] ETAPA_COD_B   = 2'd3;

    localparam int DEF_DATA_W         = 4;
    localparam int DEF_TIMEOUT        = 1000;
    localparam int DEF_MAX_INTENTOS   = 3;
    localparam int DEF_BLOQUEO_CICLOS = 5000;

    // Counter width for a limit; a limit of 1 still needs one bit of storage.
    function automatic int ancho_contador(input int limite);
        return (limite > 1) ? $clog2(limite) : 1;
    endfunction

endpackage

// File: rtl/contador_limite.sv
// Loadable up-counter with clear and enable; fin flags the count LIMITE-1.
module contador_limite #(
    parameter int LIMITE = 8,
    parameter int W      = (LIMITE > 1) ? $clog2(LIMITE) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] valor,
    input  logic         en,
    output logic         fin
);

    localparam logic [W-1:0] TERMINAL = W'(LIMITE - 1);

    logic [W-1:0] cuenta;

    // Count register: clear beats load, load beats enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cuenta <= '0;
        else if (clr)
            cuenta <= '0;
        else if (load)
            cuenta <= valor;
        else if (en)
            cuenta <= cuenta + 1'b1;
    end

    assign fin = (cuenta == TERMINAL);

endmodule

// File: rtl/control_validacion.sv
// Three-stage code validation controller with stage timeout and attempt lockout.
//
// state   | meaning
// IDLE    | waiting for iniciar; entries ignored
// ETAPA_T | expecting clave_t
// ETAPA_P | expecting clave_p
// ETAPA_B | expecting clave_b
// BLOQUEO | too many wrong entries; all inputs ignored until the lockout expires
module control_validacion
    import validacion_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT        = DEF_TIMEOUT,
    parameter int MAX_INTENTOS   = DEF_MAX_INTENTOS,
    parameter int BLOQUEO_CICLOS = DEF_BLOQUEO_CICLOS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iniciar,
    input  logic [DATA_W-1:0] dato,
    input  logic              dato_valido,
    input  logic [DATA_W-1:0] clave_t,
    input  logic [DATA_W-1:0] clave_p,
    input  logic [DATA_W-1:0] clave_b,
    output logic              validat,
    output logic              validap,
    output logic              validab,
    output logic [1:0]        etapa,
    output logic              error,
    output logic              tiempo_agotado,
    output logic              bloqueo,
    output logic [1:0]        intentos
);

    localparam int TW  = ancho_contador(TIMEOUT);
    localparam int BW  = ancho_contador(BLOQUEO_CICLOS);
    localparam int IWC = ancho_contador(MAX_INTENTOS + 1);
    localparam int IW  = (IWC < 2) ? 2 : IWC;
    localparam logic [IW-1:0] ATT_MAX = IW'(MAX_INTENTOS);

    estado_t           estado;
    logic [IW-1:0]     att;
    logic [IW-1:0]     att_inc;
    logic [1:0]        att_inc_sat;
    logic [DATA_W-1:0] clave_sel;
    logic              en_etapa;
    logic              acierto;
    logic              t_en;
    logic              t_fin;
    logic              b_en;
    logic              b_fin;

    // Select the code belonging to the current stage.
    always_comb begin
        clave_sel = clave_t;
        case (estado)
            ETAPA_P: clave_sel = clave_p;
            ETAPA_B: clave_sel = clave_b;
            default: clave_sel = clave_t;
        endcase
    end

    assign en_etapa    = (estado == ETAPA_T) || (estado == ETAPA_P) || (estado == ETAPA_B);
    assign acierto     = (dato == clave_sel);
    assign att_inc     = att + 1'b1;
    assign att_inc_sat = (att_inc > IW'(3)) ? 2'd3 : 2'(att_inc);

    // Timeout counter only runs through idle stage cycles; any entry or expiry restarts it.
    assign t_en = en_etapa && !dato_valido && !t_fin;
    assign b_en = (estado == BLOQUEO) && !b_fin;

    contador_limite #(.LIMITE(TIMEOUT), .W(TW)) u_timeout (
        .clk   (clk),
        .reset (reset),
        .clr   (!t_en),
        .load  (1'b0),
        .valor ('0),
        .en    (t_en),
        .fin   (t_fin)
    );

    contador_limite #(.LIMITE(BLOQUEO_CICLOS), .W(BW)) u_bloqueo (
        .clk   (clk),
        .reset (reset),
        .clr   (!b_en),
        .load  (1'b0),
        .valor ('0),
        .en    (b_en),
        .fin   (b_fin)
    );

    // Sequencing FSM with registered pulses, stage code, lockout level and attempt count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado         <= IDLE;
            etapa          <= ETAPA_NINGUNA;
            validat        <= 1'b0;
            validap        <= 1'b0;
            validab        <= 1'b0;
            error          <= 1'b0;
            tiempo_agotado <= 1'b0;
            bloqueo        <= 1'b0;
            intentos       <= 2'd0;
            att            <= '0;
        end else begin
            validat        <= 1'b0;
            validap        <= 1'b0;
            validab        <= 1'b0;
            error          <= 1'b0;
            tiempo_agotado <= 1'b0;
            case (estado)
                IDLE: begin
                    if (iniciar) begin
                        estado   <= ETAPA_T;
                        etapa    <= ETAPA_COD_T;
                        att      <= '0;
                        intentos <= 2'd0;
                    end
                end
                ETAPA_T, ETAPA_P, ETAPA_B: begin
                    if (dato_valido) begin
                        if (acierto) begin
                            case (estado)
                                ETAPA_T: begin
                                    validat <= 1'b1;
                                    estado  <= ETAPA_P;
                                    etapa   <= ETAPA_COD_P;
                                end
                                ETAPA_P: begin
                                    validap <= 1'b1;
                                    estado  <= ETAPA_B;
                                    etapa   <= ETAPA_COD_B;
                                end
                                default: begin
                                    validab <= 1'b1;
                                    estado  <= IDLE;
                                    etapa   <= ETAPA_NINGUNA;
                                end
                            endcase
                        end else begin
                            error    <= 1'b1;
                            att      <= att_inc;
                            intentos <= att_inc_sat;
                            if (att_inc == ATT_MAX) begin
                                estado  <= BLOQUEO;
                                etapa   <= ETAPA_NINGUNA;
                                bloqueo <= 1'b1;
                            end
                        end
                    end else if (t_fin) begin
                        tiempo_agotado <= 1'b1;
                        estado         <= IDLE;
                        etapa          <= ETAPA_NINGUNA;
                    end
                end
                BLOQUEO: begin
                    if (b_fin) begin
                        estado   <= IDLE;
                        bloqueo  <= 1'b0;
                        att      <= '0;
                        intentos <= 2'd0;
                    end
                end
                default: begin
                    estado <= IDLE;
                    etapa  <= ETAPA_NINGUNA;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_validacion.sv
// Scoreboard bench for control_validacion: stimulus queues expected pulses, a monitor checks them.
module tb_control_validacion;

    localparam int DW = 4;
    localparam int TO = 8;
    localparam int MI = 3;
    localparam int BC = 20;

    localparam logic [4:0] M_T   = 5'b10000;
    localparam logic [4:0] M_P   = 5'b01000;
    localparam logic [4:0] M_B   = 5'b00100;
    localparam logic [4:0] M_ERR = 5'b00010;
    localparam logic [4:0] M_TO  = 5'b00001;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          iniciar = 1'b0;
    logic [DW-1:0] dato = '0;
    logic          dato_valido = 1'b0;
    logic [DW-1:0] clave_t = 4'h3;
    logic [DW-1:0] clave_p = 4'h7;
    logic [DW-1:0] clave_b = 4'hA;
    logic          validat, validap, validab, error, tiempo_agotado, bloqueo;
    logic [1:0]    etapa, intentos;

    typedef struct {
        logic [4:0] mask;
        logic [1:0] etapa;
        logic [1:0] intentos;
        logic       bloqueo;
        longint     t;
    } esperado_t;

    esperado_t cola[$];
    esperado_t e_mon;
    logic [4:0] m_mon;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    control_validacion #(
        .DATA_W(DW), .TIMEOUT(TO), .MAX_INTENTOS(MI), .BLOQUEO_CICLOS(BC)
    ) dut (
        .clk(clk), .reset(reset), .iniciar(iniciar), .dato(dato), .dato_valido(dato_valido),
        .clave_t(clave_t), .clave_p(clave_p), .clave_b(clave_b),
        .validat(validat), .validap(validap), .validab(validab), .etapa(etapa),
        .error(error), .tiempo_agotado(tiempo_agotado), .bloqueo(bloqueo), .intentos(intentos)
    );

    function automatic void chk(input string nombre, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nombre, act, exp, $time);
        end
    endfunction

    task automatic esperar(input logic [4:0] m, input logic [1:0] et, input logic [1:0] it,
                           input logic bq, input longint t);
        esperado_t e;
        e.mask = m; e.etapa = et; e.intentos = it; e.bloqueo = bq; e.t = t;
        cola.push_back(e);
    endtask

    task automatic entrada(input logic [3:0] v, input logic [4:0] m, input logic [1:0] et,
                           input logic [1:0] it, input logic bq);
        @(negedge clk);
        dato = v;
        dato_valido = 1'b1;
        esperar(m, et, it, bq, $time + 10);
        @(negedge clk);
        dato_valido = 1'b0;
    endtask

    task automatic arrancar();
        @(negedge clk);
        iniciar = 1'b1;
        @(negedge clk);
        iniciar = 1'b0;
        chk("etapa_tras_iniciar", etapa, 1);
    endtask

    task automatic chk_todo_cero(input string nombre);
        chk({nombre, "_pulsos"}, {validat, validap, validab, error, tiempo_agotado}, 0);
        chk({nombre, "_etapa"}, etapa, 0);
        chk({nombre, "_bloqueo"}, bloqueo, 0);
        chk({nombre, "_intentos"}, intentos, 0);
    endtask

    // Monitor: every output pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        m_mon = {validat, validap, validab, error, tiempo_agotado};
        if (!reset && m_mon != 5'b0) begin
            chk("pulso_unico", $countones(m_mon), 1);
            if (cola.size() == 0) begin
                chk("pulso_inesperado", m_mon, 0);
            end else begin
                e_mon = cola.pop_front();
                chk("tipo_pulso", m_mon, e_mon.mask);
                chk("etapa_con_pulso", etapa, e_mon.etapa);
                chk("intentos_con_pulso", intentos, e_mon.intentos);
                chk("bloqueo_con_pulso", bloqueo, e_mon.bloqueo);
                chk("instante_pulso", $time, e_mon.t);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint ts;
        repeat (2) @(negedge clk);
        chk_todo_cero("reset");
        reset = 1'b0;

        // Full correct sequence.
        arrancar();
        entrada(4'h3, M_T, 2, 0, 0);
        entrada(4'h7, M_P, 3, 0, 0);
        entrada(4'hA, M_B, 0, 0, 0);
        chk("etapa_fin_secuencia", etapa, 0);

        // Three wrong entries lead to lockout; inputs ignored throughout.
        arrancar();
        entrada(4'h5, M_ERR, 1, 1, 0);
        entrada(4'h5, M_ERR, 1, 2, 0);
        entrada(4'h5, M_ERR, 0, 3, 1);
        for (int i = 0; i < BC; i++) begin
            chk("bloqueo_activo", bloqueo, 1);
            chk("etapa_en_bloqueo", etapa, 0);
            iniciar     = (i < BC - 1);
            dato_valido = (i < BC - 1);
            dato        = 4'h3;
            @(negedge clk);
        end
        chk("bloqueo_fin", bloqueo, 0);
        chk("intentos_tras_bloqueo", intentos, 0);
        chk("etapa_tras_bloqueo", etapa, 0);

        // Timeout with no entry.
        arrancar();
        ts = $time;
        esperar(M_TO, 0, 0, 0, ts + 80);
        repeat (8) @(negedge clk);
        chk("etapa_tras_timeout", etapa, 0);

        // Correct entry on expiry cycle, then error in P, then iniciar ignored in B.
        arrancar();
        repeat (6) @(negedge clk);
        entrada(4'h3, M_T, 2, 0, 0);
        entrada(4'h1, M_ERR, 2, 1, 0);
        entrada(4'h7, M_P, 3, 1, 0);
        @(negedge clk); iniciar = 1'b1;
        @(negedge clk); iniciar = 1'b0;
        @(negedge clk); iniciar = 1'b1;
        @(negedge clk); iniciar = 1'b0;
        chk("etapa_b_con_iniciar", etapa, 3);
        entrada(4'hA, M_B, 0, 1, 0);
        chk("intentos_conservados", intentos, 1);

        // Strobes in IDLE do nothing.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            dato_valido = 1'b1;
            dato = (i % 2 == 0) ? 4'h3 : 4'h7;
        end
        @(negedge clk);
        dato_valido = 1'b0;
        chk("etapa_idle_strobes", etapa, 0);
        chk("intentos_idle_strobes", intentos, 1);

        // Back-to-back entries.
        arrancar();
        chk("intentos_tras_iniciar", intentos, 0);
        @(negedge clk); dato_valido = 1'b1; dato = 4'h3; esperar(M_T, 2, 0, 0, $time + 10);
        @(negedge clk); dato = 4'h7; esperar(M_P, 3, 0, 0, $time + 10);
        @(negedge clk); dato = 4'hA; esperar(M_B, 0, 0, 0, $time + 10);
        @(negedge clk); dato_valido = 1'b0;
        chk("etapa_tras_rafaga", etapa, 0);

        // Asynchronous reset during ETAPA_P.
        arrancar();
        entrada(4'h3, M_T, 2, 0, 0);
        entrada(4'h2, M_ERR, 2, 1, 0);
        #2 reset = 1'b1;
        #1 chk_todo_cero("reset_en_p");
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("etapa_tras_reset_p", etapa, 0);

        // Asynchronous reset during lockout.
        arrancar();
        entrada(4'h9, M_ERR, 1, 1, 0);
        entrada(4'h9, M_ERR, 1, 2, 0);
        entrada(4'h9, M_ERR, 0, 3, 1);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1 chk_todo_cero("reset_en_bloqueo");
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk_todo_cero("tras_reset_bloqueo");
        arrancar();
        ts = $time;
        esperar(M_TO, 0, 0, 0, ts + 80);
        repeat (10) @(negedge clk);

        chk("cola_vacia", cola.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
